pulse_train_sequencer: RTL and testbench

Upstream stage of spi_controller. Generates the stimulation pulse-train waveform as a stream of 16-bit DAC codes plus the SPI mode word (nop/write). Output changes only on SPI frame boundaries, so each 24-bit command is stable for the whole shift. Configured and triggered from Opal Kelly wires/triggers; drives spi_controller's data_from_user and mode directly.

---
 rtl/osc1_pkg.sv | 26 ++
 rtl/frame_timer.sv | 29 ++
 rtl/pulse_train_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pulse_train_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc1_pkg.sv
// Shared types and constants for the stimulation pulse-train sequencer.
package osc1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HIGH,
    LOW,
    PARK
  } state_e;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  localparam int          DEFAULT_FRAME_LEN = 32;
  localparam logic [15:0] DEFAULT_ZERO_CODE = 16'h0000;

  // Low-phase length in frames; a pulse width at or above the period means
  // back-to-back high phases with no gap.
  function automatic logic [15:0] calc_low_len(input logic [15:0] period,
                                               input logic [15:0] width);
    return (period > width) ? (period - width) : 16'd0;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running SPI frame counter kept in lockstep with spi_controller.
module frame_timer #(
  parameter int FRAME_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick,
  output logic frame_start
);

  localparam int CW = $clog2(FRAME_LEN);

  logic [CW-1:0] frm_cnt_q;
  logic [CW-1:0] frm_cnt_d;

  // Count 0..FRAME_LEN-1 and wrap at the last clock of the frame.
  always_comb begin
    frame_tick  = (frm_cnt_q == CW'(FRAME_LEN - 1));
    frame_start = (frm_cnt_q == '0);
    frm_cnt_d   = frame_tick ? '0 : frm_cnt_q + 1'b1;
  end

  // Frame counter register; reset restarts the frame alongside spi_controller.
  always_ff @(posedge clk) begin
    if (rst) frm_cnt_q <= '0;
    else     frm_cnt_q <= frm_cnt_d;
  end

endmodule

// File: rtl/pulse_train_sequencer.sv
// Pulse-train sequencer: turns a snapshot of amplitude/width/period/count into
// a frame-aligned stream of DAC codes and SPI mode words for spi_controller.
module pulse_train_sequencer
  import osc1_pkg::*;
#(
  parameter int          FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter logic [15:0] ZERO_CODE = DEFAULT_ZERO_CODE,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             stop,
  input  logic [15:0]      amplitude,
  input  logic [15:0]      pulse_width,
  input  logic [15:0]      period,
  input  logic [CNT_W-1:0] n_pulses,
  output logic [15:0]      data_to_dac,
  output logic [1:0]       mode,
  output logic             frame_start,
  output logic             busy,
  output logic             pulse_active,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pulse_count
);

  logic frame_tick;

  frame_timer #(.FRAME_LEN(FRAME_LEN)) u_frame_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .frame_start (frame_start)
  );

  state_e           state_q, state_d;
  logic             abort_q, abort_d;
  logic [15:0]      phase_q, phase_d;
  logic [15:0]      amp_q, amp_d;
  logic [15:0]      pw_q, pw_d;
  logic [15:0]      low_len_q, low_len_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             abort_now;
  logic             pulse_last;
  logic [CNT_W-1:0] count_inc;

  // Next-state logic: everything except trigger handling, done and err moves
  // only on frame_tick so each SPI command is stable for a whole shift.
  always_comb begin
    state_d       = state_q;
    abort_d       = abort_q;
    phase_d       = phase_q;
    amp_d         = amp_q;
    pw_d          = pw_q;
    low_len_d     = low_len_q;
    n_d           = n_q;
    pulse_count_d = pulse_count_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    abort_now  = abort_q | stop;
    pulse_last = (n_q != '0) &&
                 (({1'b0, pulse_count_q} + 1'b1) == {1'b0, n_q});
    count_inc  = (pulse_count_q == '1) ? pulse_count_q : pulse_count_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (trigger && !stop) begin
          if (pulse_width == 16'd0) begin
            err_d = 1'b1;
          end else begin
            amp_d         = amplitude;
            pw_d          = pulse_width;
            low_len_d     = calc_low_len(period, pulse_width);
            n_d           = n_pulses;
            pulse_count_d = '0;
            abort_d       = 1'b0;
            state_d       = ARMED;
          end
        end
      end

      ARMED: begin
        if (stop) abort_d = 1'b1;
        if (frame_tick) begin
          if (abort_now) begin
            abort_d = 1'b0;
            state_d = PARK;
          end else begin
            phase_d = 16'd1;
            state_d = HIGH;
          end
        end
      end

      HIGH: begin
        if (stop) abort_d = 1'b1;
        if (frame_tick) begin
          if (phase_q == pw_q) begin
            pulse_count_d = count_inc;
            if (abort_now || pulse_last) begin
              abort_d = 1'b0;
              state_d = PARK;
            end else if (low_len_q == 16'd0) begin
              phase_d = 16'd1;
              state_d = HIGH;
            end else begin
              phase_d = 16'd1;
              state_d = LOW;
            end
          end else if (abort_now) begin
            abort_d = 1'b0;
            state_d = PARK;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end

      LOW: begin
        if (stop) abort_d = 1'b1;
        if (frame_tick) begin
          if (abort_now) begin
            abort_d = 1'b0;
            state_d = PARK;
          end else if (phase_q == low_len_q) begin
            phase_d = 16'd1;
            state_d = HIGH;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end

      PARK: begin
        if (frame_tick) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and snapshot registers; reset drops straight to IDLE with no park frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      abort_q       <= 1'b0;
      phase_q       <= 16'd0;
      amp_q         <= 16'd0;
      pw_q          <= 16'd0;
      low_len_q     <= 16'd0;
      n_q           <= '0;
      pulse_count_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      phase_q       <= phase_d;
      amp_q         <= amp_d;
      pw_q          <= pw_d;
      low_len_q     <= low_len_d;
      n_q           <= n_d;
      pulse_count_q <= pulse_count_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Output decode from the registered state, so outputs change only with state.
  always_comb begin
    data_to_dac = ZERO_CODE;
    mode        = MODE_NOP;
    case (state_q)
      HIGH: begin
        data_to_dac = amp_q;
        mode        = MODE_WRITE;
      end
      LOW, PARK: begin
        mode = MODE_WRITE;
      end
      default: ;
    endcase
    busy         = (state_q != IDLE);
    pulse_active = (state_q == HIGH);
    done         = done_q;
    err          = err_q;
    pulse_count  = pulse_count_q;
  end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Directed testbench for pulse_train_sequencer: frame tables plus hand sequences.
module tb_pulse_train_sequencer;

  logic        clk;
  logic        rst;
  logic        trigger;
  logic        stop;
  logic [15:0] amplitude;
  logic [15:0] pulse_width;
  logic [15:0] period;
  logic [7:0]  n_pulses;
  logic [15:0] data_to_dac;
  logic [1:0]  mode;
  logic        frame_start;
  logic        busy;
  logic        pulse_active;
  logic        done;
  logic        err;
  logic [7:0]  pulse_count;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic        busy;
    logic        active;
    logic        done;
    logic [7:0]  count;
  } frame_vec_t;

  frame_vec_t tbl[$];

  pulse_train_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .stop         (stop),
    .amplitude    (amplitude),
    .pulse_width  (pulse_width),
    .period       (period),
    .n_pulses     (n_pulses),
    .data_to_dac  (data_to_dac),
    .mode         (mode),
    .frame_start  (frame_start),
    .busy         (busy),
    .pulse_active (pulse_active),
    .done         (done),
    .err          (err),
    .pulse_count  (pulse_count)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something locks up
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] amp, input logic [15:0] pw,
                               input logic [15:0] per, input logic [7:0] n);
    amplitude   = amp;
    pulse_width = pw;
    period      = per;
    n_pulses    = n;
    trigger     = 1'b1;
    step(1);
    trigger     = 1'b0;
  endtask

  task automatic waitFrameStart();
    int guard;
    guard = 0;
    while (!frame_start && guard < 64) begin
      step(1);
      guard++;
    end
    checkOutput("frame_align", {31'd0, frame_start}, 32'd1);
  endtask

  // Walks the frame table from frm_cnt==0: full check at frame start, data/mode mid-frame
  task automatic runTable(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      checkOutput($sformatf("%s[%0d].data", tag, i), {16'd0, data_to_dac}, {16'd0, tbl[i].data});
      checkOutput($sformatf("%s[%0d].mode", tag, i), {30'd0, mode}, {30'd0, tbl[i].mode});
      checkOutput($sformatf("%s[%0d].busy", tag, i), {31'd0, busy}, {31'd0, tbl[i].busy});
      checkOutput($sformatf("%s[%0d].active", tag, i), {31'd0, pulse_active}, {31'd0, tbl[i].active});
      checkOutput($sformatf("%s[%0d].done", tag, i), {31'd0, done}, {31'd0, tbl[i].done});
      checkOutput($sformatf("%s[%0d].count", tag, i), {24'd0, pulse_count}, {24'd0, tbl[i].count});
      step(16);
      checkOutput($sformatf("%s[%0d].mid_data", tag, i), {16'd0, data_to_dac}, {16'd0, tbl[i].data});
      checkOutput($sformatf("%s[%0d].mid_mode", tag, i), {30'd0, mode}, {30'd0, tbl[i].mode});
      step(16);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    trigger     = 1'b0;
    stop        = 1'b0;
    amplitude   = 16'h0;
    pulse_width = 16'h0;
    period      = 16'h0;
    n_pulses    = 8'h0;

    // ---------------- reset state ----------------
    step(3);
    rst = 1'b0;
    checkOutput("rst.frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("rst.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("rst.mode", {30'd0, mode}, 32'd0);
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst.done", {31'd0, done}, 32'd0);
    checkOutput("rst.err", {31'd0, err}, 32'd0);
    checkOutput("rst.count", {24'd0, pulse_count}, 32'd0);
    step(1);
    checkOutput("timer.mid", {31'd0, frame_start}, 32'd0);
    step(31);
    checkOutput("timer.wrap", {31'd0, frame_start}, 32'd1);

    // ---------------- zero-width trigger rejected ----------------
    step(2);
    applyStimulus(16'h4000, 16'd0, 16'd5, 8'd3);
    checkOutput("err.pulse", {31'd0, err}, 32'd1);
    checkOutput("err.busy", {31'd0, busy}, 32'd0);
    checkOutput("err.mode", {30'd0, mode}, 32'd0);
    step(1);
    checkOutput("err.one_cycle", {31'd0, err}, 32'd0);
    checkOutput("err.still_idle", {31'd0, busy}, 32'd0);

    // ---------------- trigger+stop in IDLE: stop wins ----------------
    stop = 1'b1;
    applyStimulus(16'h4000, 16'd2, 16'd5, 8'd3);
    stop = 1'b0;
    checkOutput("trgstop.busy", {31'd0, busy}, 32'd0);
    checkOutput("trgstop.err", {31'd0, err}, 32'd0);
    stop = 1'b1;
    applyStimulus(16'h4000, 16'd0, 16'd5, 8'd3);
    stop = 1'b0;
    checkOutput("trgstop0.err", {31'd0, err}, 32'd0);

    // ---------------- 3 pulses, width 2, period 5 ----------------
    waitFrameStart();
    step(5);
    applyStimulus(16'h4000, 16'd2, 16'd5, 8'd3);
    amplitude = 16'hFFFF;
    n_pulses  = 8'd1;
    period    = 16'd1;
    checkOutput("armed.busy", {31'd0, busy}, 32'd1);
    checkOutput("armed.mode", {30'd0, mode}, 32'd0);
    checkOutput("armed.data", {16'd0, data_to_dac}, 32'h0);
    waitFrameStart();
    tbl.delete();
    for (int p = 0; p < 3; p++) begin
      tbl.push_back('{16'h4000, 2'b01, 1'b1, 1'b1, 1'b0, 8'(p)});
      tbl.push_back('{16'h4000, 2'b01, 1'b1, 1'b1, 1'b0, 8'(p)});
      if (p < 2) begin
        for (int l = 0; l < 3; l++)
          tbl.push_back('{16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'(p + 1)});
      end
    end
    tbl.push_back('{16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'd3});
    tbl.push_back('{16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 8'd3});
    runTable("n3");

    // ---------------- width >= period: continuous high ----------------
    step(3);
    applyStimulus(16'h2AAA, 16'd4, 16'd3, 8'd2);
    waitFrameStart();
    tbl.delete();
    for (int f = 0; f < 8; f++)
      tbl.push_back('{16'h2AAA, 2'b01, 1'b1, 1'b1, 1'b0, 8'(f / 4)});
    tbl.push_back('{16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'd2});
    tbl.push_back('{16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 8'd2});
    runTable("wide");

    // ---------------- endless run stopped mid-HIGH ----------------
    step(2);
    applyStimulus(16'h1234, 16'd1, 16'd2, 8'd0);
    waitFrameStart();
    checkOutput("stop.h1.data", {16'd0, data_to_dac}, 32'h1234);
    step(32);
    checkOutput("stop.l1.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("stop.l1.mode", {30'd0, mode}, 32'd1);
    applyStimulus(16'h5555, 16'd0, 16'd9, 8'd1);
    checkOutput("busytrg.err", {31'd0, err}, 32'd0);
    checkOutput("busytrg.busy", {31'd0, busy}, 32'd1);
    step(31);
    checkOutput("stop.h2.data", {16'd0, data_to_dac}, 32'h1234);
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checkOutput("stop.hold.data", {16'd0, data_to_dac}, 32'h1234);
    checkOutput("stop.hold.active", {31'd0, pulse_active}, 32'd1);
    step(21);
    checkOutput("stop.park.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("stop.park.mode", {30'd0, mode}, 32'd1);
    checkOutput("stop.park.busy", {31'd0, busy}, 32'd1);
    checkOutput("stop.park.active", {31'd0, pulse_active}, 32'd0);
    step(32);
    checkOutput("stop.idle.done", {31'd0, done}, 32'd1);
    checkOutput("stop.idle.mode", {30'd0, mode}, 32'd0);
    checkOutput("stop.idle.busy", {31'd0, busy}, 32'd0);
    step(1);
    checkOutput("stop.done_one", {31'd0, done}, 32'd0);
    step(40);
    checkOutput("stop.after.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("stop.after.mode", {30'd0, mode}, 32'd0);

    // ---------------- reset mid-HIGH then fresh run ----------------
    waitFrameStart();
    step(1);
    applyStimulus(16'h7777, 16'd3, 16'd6, 8'd0);
    waitFrameStart();
    checkOutput("rstmid.high", {16'd0, data_to_dac}, 32'h7777);
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("rstmid.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("rstmid.mode", {30'd0, mode}, 32'd0);
    checkOutput("rstmid.busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid.frame_start", {31'd0, frame_start}, 32'd1);
    step(3);
    applyStimulus(16'h0ABC, 16'd1, 16'd1, 8'd1);
    checkOutput("rerun.armed", {31'd0, busy}, 32'd1);
    checkOutput("rerun.count_clr", {24'd0, pulse_count}, 32'd0);
    step(28);
    checkOutput("rerun.frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("rerun.data", {16'd0, data_to_dac}, 32'h0ABC);
    checkOutput("rerun.active", {31'd0, pulse_active}, 32'd1);
    step(32);
    checkOutput("rerun.park.mode", {30'd0, mode}, 32'd1);
    checkOutput("rerun.park.data", {16'd0, data_to_dac}, 32'h0000);
    checkOutput("rerun.park.count", {24'd0, pulse_count}, 32'd1);
    step(32);
    checkOutput("rerun.done", {31'd0, done}, 32'd1);
    checkOutput("rerun.idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
